// File: rtl/uart_io_ctrl.sv
// UART responder for the exec stage's IN/OUT requests: 8N1 transmitter for 1/2/4-byte OUT words,
// receiver with an RX FIFO that assembles RD_BYTES-byte IN words.
module uart_io_ctrl #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_AW     = 4,
  parameter int RD_BYTES    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        uart_wenable,
  input  logic [1:0]  uart_wsz,
  input  logic [31:0] uart_wd,
  output logic        uart_wdone,
  input  logic        uart_renable,
  output logic [31:0] uart_rd,
  output logic        uart_rdone,
  output logic        txd,
  input  logic        rxd,
  output logic        rx_overrun,
  output logic        rx_ferr
);

  localparam int                 CNT_W     = $clog2(CLK_PER_BIT);
  localparam int                 DEPTH     = 2 ** FIFO_AW;
  localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [FIFO_AW:0]   FIFO_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [1:0]         RD_LAST   = 2'(RD_BYTES - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_START = 2'd1, ST_DATA = 2'd2, ST_STOP = 2'd3} ser_state_e;

  ser_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [1:0]        tx_left_q, tx_left_d;
  logic [31:0]       tx_data_q, tx_data_d;
  logic              txd_q, txd_d;
  logic              wdone_q, wdone_d;
  logic              tx_bit_end_s;

  ser_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic              rx_push_s, rx_ferr_set_s;

  logic [7:0]        fifo_mem_q [DEPTH];
  logic [FIFO_AW-1:0] fifo_wptr_q, fifo_rptr_q;
  logic [FIFO_AW:0]  fifo_cnt_q;
  logic              fifo_full_s, fifo_empty_s, push_ok_s, pop_s;
  logic              overrun_q, ferr_q;

  logic              pend_q, pend_d;
  logic [1:0]        rcnt_q, rcnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       rd_q, rd_d;
  logic              rdone_q, rdone_d;

  assign tx_bit_end_s = (tx_cnt_q == BIT_LAST);

  // TX next state: txd_d is derived from the next state so every bit lasts exactly CLK_PER_BIT cycles
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_bit_end_s ? '0 : tx_cnt_q + CNT_W'(1);
    tx_bit_d   = tx_bit_q;
    tx_left_d  = tx_left_q;
    tx_data_d  = tx_data_q;
    txd_d      = txd_q;
    wdone_d    = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        tx_cnt_d = '0;
        if (uart_wenable) begin
          tx_state_d = ST_START;
          tx_data_d  = uart_wd;
          tx_left_d  = uart_wsz[1] ? 2'd3 : (uart_wsz[0] ? 2'd1 : 2'd0);
          txd_d      = 1'b0;
        end else begin
          txd_d = 1'b1;
        end
      end
      ST_START: begin
        if (tx_bit_end_s) begin
          tx_state_d = ST_DATA;
          tx_bit_d   = 3'd0;
          txd_d      = tx_data_q[0];
        end else begin
          txd_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (tx_bit_end_s) begin
          // shifting one bit per data bit brings the next byte into [7:0] after eight bits
          tx_data_d = {1'b0, tx_data_q[31:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            txd_d    = tx_data_q[1];
          end
        end else begin
          txd_d = tx_data_q[0];
        end
      end
      ST_STOP: begin
        if (tx_bit_end_s && (tx_left_q != 2'd0)) begin
          tx_state_d = ST_START;
          tx_left_d  = tx_left_q - 2'd1;
          txd_d      = 1'b0;
        end else if (tx_bit_end_s) begin
          tx_state_d = ST_IDLE;
          txd_d      = 1'b1;
          wdone_d    = 1'b1;
        end else begin
          txd_d = 1'b1;
        end
      end
      default: begin
        tx_state_d = ST_IDLE;
        txd_d      = 1'b1;
      end
    endcase
  end

  // TX state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_left_q  <= 2'd0;
      tx_data_q  <= 32'd0;
      txd_q      <= 1'b1;
      wdone_q    <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_left_q  <= tx_left_d;
      tx_data_q  <= tx_data_d;
      txd_q      <= txd_d;
      wdone_q    <= wdone_d;
    end
  end

  // RX next state: start bit re-checked at half a bit, then samples every CLK_PER_BIT cycles
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q + CNT_W'(1);
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_push_s     = 1'b0;
    rx_ferr_set_s = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync2_q) begin
          rx_state_d = ST_START;
        end else begin
          rx_state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync2_q ? ST_IDLE : ST_DATA;
        end else begin
          rx_state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = ST_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_state_d    = ST_IDLE;
          rx_push_s     = rx_sync2_q;
          rx_ferr_set_s = !rx_sync2_q;
        end else begin
          rx_state_d = ST_STOP;
        end
      end
      default: begin
        rx_state_d = ST_IDLE;
      end
    endcase
  end

  // RX synchroniser, edge history and state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
    end else begin
      rx_sync1_q <= rxd;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  assign fifo_full_s  = (fifo_cnt_q == FIFO_FULL);
  assign fifo_empty_s = (fifo_cnt_q == '0);
  assign push_ok_s    = rx_push_s && !fifo_full_s;
  assign pop_s        = pend_q && !fifo_empty_s;

  // FIFO storage; contents need no reset because the count gates every read
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      fifo_mem_q[fifo_wptr_q] <= rx_shift_q;
    end
  end

  // FIFO pointers, count and sticky RX error flags
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fifo_wptr_q <= '0;
      fifo_rptr_q <= '0;
      fifo_cnt_q  <= '0;
      overrun_q   <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      if (push_ok_s) fifo_wptr_q <= fifo_wptr_q + FIFO_AW'(1);
      if (pop_s)     fifo_rptr_q <= fifo_rptr_q + FIFO_AW'(1);
      case ({push_ok_s, pop_s})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + (FIFO_AW + 1)'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - (FIFO_AW + 1)'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      if (rx_push_s && fifo_full_s) overrun_q <= 1'b1;
      if (rx_ferr_set_s)            ferr_q    <= 1'b1;
    end
  end

  // IN assembly: one byte per cycle while pending, result registered on the last pop
  always_comb begin
    pend_d  = pend_q;
    rcnt_d  = rcnt_q;
    asm_d   = asm_q;
    rd_d    = rd_q;
    rdone_d = 1'b0;
    if (!pend_q && uart_renable) begin
      pend_d = 1'b1;
      rcnt_d = 2'd0;
      asm_d  = 32'd0;
    end else if (pop_s) begin
      asm_d[{rcnt_q, 3'b000} +: 8] = fifo_mem_q[fifo_rptr_q];
      if (rcnt_q == RD_LAST) begin
        rd_d    = asm_d;
        rdone_d = 1'b1;
        pend_d  = 1'b0;
      end else begin
        rcnt_d = rcnt_q + 2'd1;
      end
    end else begin
      pend_d = pend_q;
    end
  end

  // IN handshake registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend_q  <= 1'b0;
      rcnt_q  <= 2'd0;
      asm_q   <= 32'd0;
      rd_q    <= 32'd0;
      rdone_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      rcnt_q  <= rcnt_d;
      asm_q   <= asm_d;
      rd_q    <= rd_d;
      rdone_q <= rdone_d;
    end
  end

  assign txd        = txd_q;
  assign uart_wdone = wdone_q;
  assign uart_rd    = rd_q;
  assign uart_rdone = rdone_q;
  assign rx_overrun = overrun_q;
  assign rx_ferr    = ferr_q;

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed bench for uart_io_ctrl at CLK_PER_BIT=4, FIFO_AW=2, RD_BYTES=4.
module tb_uart_io_ctrl;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        uart_wenable;
  logic [1:0]  uart_wsz;
  logic [31:0] uart_wd;
  logic        uart_wdone;
  logic        uart_renable;
  logic [31:0] uart_rd;
  logic        uart_rdone;
  logic        txd;
  logic        rxd;
  logic        rx_overrun;
  logic        rx_ferr;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  uart_io_ctrl #(.CLK_PER_BIT(CPB), .FIFO_AW(2), .RD_BYTES(4)) dut (
    .clk(clk), .rstn(rstn),
    .uart_wenable(uart_wenable), .uart_wsz(uart_wsz), .uart_wd(uart_wd), .uart_wdone(uart_wdone),
    .uart_renable(uart_renable), .uart_rd(uart_rd), .uart_rdone(uart_rdone),
    .txd(txd), .rxd(rxd), .rx_overrun(rx_overrun), .rx_ferr(rx_ferr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Issue an OUT and compare txd every cycle against the hand-built 8N1 frames.
  task automatic do_out(input logic [1:0] wsz, input logic [31:0] wd, input int nb, input bit poke);
    int wd_cnt;
    logic [7:0] b;
    logic e;
    uart_wenable = 1'b1; uart_wsz = wsz; uart_wd = wd;
    @(negedge clk);
    uart_wenable = 1'b0;
    wd_cnt = 0;
    for (int k = 0; k < nb; k++) begin
      b = wd[8*k +: 8];
      for (int i = 0; i < 10; i++) begin
        for (int c = 0; c < CPB; c++) begin
          e = (i == 0) ? 1'b0 : ((i == 9) ? 1'b1 : b[i-1]);
          check($sformatf("txd b%0d bit%0d c%0d", k, i, c), 32'(txd), 32'(e));
          if (uart_wdone) wd_cnt++;
          uart_wenable = (poke && k == 0 && i == 3 && c == 0);
          if (uart_wenable) begin
            uart_wd = 32'hFFFF_FFFF; uart_wsz = 2'b00;
          end
          @(negedge clk);
          uart_wenable = 1'b0;
        end
      end
    end
    check("wdone_after_stop", 32'(uart_wdone), 32'd1);
    check("txd_idle_after", 32'(txd), 32'd1);
    if (uart_wdone) wd_cnt++;
    repeat (3) begin
      @(negedge clk);
      if (uart_wdone) wd_cnt++;
    end
    check("wdone_count", 32'(wd_cnt), 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int idle);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (idle) @(negedge clk);
  endtask

  // IN request; returns cycles until rdone (1 = first cycle after the request).
  task automatic do_in(output int lat, output logic [31:0] data);
    uart_renable = 1'b1;
    @(negedge clk);
    uart_renable = 1'b0;
    lat = 1;
    while (!uart_rdone && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    data = uart_rd;
  endtask

  initial begin
    int lat;
    int cnt;
    logic [31:0] data;
    rstn = 1'b0; uart_wenable = 1'b0; uart_wsz = 2'b00; uart_wd = 32'd0;
    uart_renable = 1'b0; rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_wdone", 32'(uart_wdone), 32'd0);
    check("rst_rdone", 32'(uart_rdone), 32'd0);
    check("rst_rd", uart_rd, 32'd0);
    check("rst_overrun", 32'(rx_overrun), 32'd0);
    check("rst_ferr", 32'(rx_ferr), 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    do_out(2'b00, 32'h0000_00A5, 1, 1'b0);
    do_out(2'b01, 32'h0000_BEEF, 2, 1'b0);
    do_out(2'b10, 32'h1122_3344, 4, 1'b1);

    // bytes buffered first, then IN
    send_rx(8'h78, 1'b1, 0); send_rx(8'h56, 1'b1, 0);
    send_rx(8'h34, 1'b1, 0); send_rx(8'h12, 1'b1, 2);
    do_in(lat, data);
    check("in_buf_latency", 32'(lat), 32'd5);
    check("in_buf_data", data, 32'h1234_5678);
    @(negedge clk);
    check("rdone_one_cycle", 32'(uart_rdone), 32'd0);
    check("rd_hold", uart_rd, 32'h1234_5678);

    // IN first, bytes arrive afterwards; a second renable while pending is ignored
    uart_renable = 1'b1;
    @(negedge clk);
    uart_renable = 1'b0;
    send_rx(8'hDE, 1'b1, 0);
    send_rx(8'hAD, 1'b1, 1);
    uart_renable = 1'b1;
    @(negedge clk);
    uart_renable = 1'b0;
    send_rx(8'hBE, 1'b1, 0);
    check("rdone_early", 32'(uart_rdone), 32'd0);
    send_rx(8'hEF, 1'b1, 0);
    @(negedge clk);
    check("rdone_at_pop", 32'(uart_rdone), 32'd0);
    @(negedge clk);
    check("rdone_after_pop", 32'(uart_rdone), 32'd1);
    check("in_wait_data", uart_rd, 32'hEFBE_ADDE);
    @(negedge clk);

    // overrun: fifth byte dropped
    send_rx(8'h01, 1'b1, 0); send_rx(8'h02, 1'b1, 0); send_rx(8'h03, 1'b1, 0);
    send_rx(8'h04, 1'b1, 0);
    check("overrun_before", 32'(rx_overrun), 32'd0);
    send_rx(8'h05, 1'b1, 2);
    check("overrun_set", 32'(rx_overrun), 32'd1);
    check("ferr_clear", 32'(rx_ferr), 32'd0);
    do_in(lat, data);
    check("ovr_latency", 32'(lat), 32'd5);
    check("ovr_data", data, 32'h0403_0201);

    // framing error, then a one-cycle glitch; neither may reach the FIFO
    send_rx(8'h5A, 1'b0, 4);
    check("ferr_set", 32'(rx_ferr), 32'd1);
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    send_rx(8'h99, 1'b1, 0); send_rx(8'h88, 1'b1, 0);
    send_rx(8'h77, 1'b1, 0); send_rx(8'h66, 1'b1, 2);
    do_in(lat, data);
    check("clean_latency", 32'(lat), 32'd5);
    check("clean_data", data, 32'h6677_8899);
    check("overrun_sticky", 32'(rx_overrun), 32'd1);
    check("ferr_sticky", 32'(rx_ferr), 32'd1);

    // reset in the middle of an OUT
    uart_wenable = 1'b1; uart_wsz = 2'b10; uart_wd = 32'h0000_0000;
    @(negedge clk);
    uart_wenable = 1'b0;
    repeat (10) @(negedge clk);
    check("txd_low_mid_out", 32'(txd), 32'd0);
    rstn = 1'b0;
    @(negedge clk);
    check("rst_mid_txd", 32'(txd), 32'd1);
    check("rst_mid_overrun", 32'(rx_overrun), 32'd0);
    check("rst_mid_ferr", 32'(rx_ferr), 32'd0);
    check("rst_mid_rd", uart_rd, 32'd0);
    rstn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (uart_wdone || !txd) cnt++;
      @(negedge clk);
    end
    check("no_wdone_after_rst", 32'(cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
